edge_stage_sequencer: RTL and testbench
=======================================

EDGE_STAGE_SEQUENCER -- requirements
Module: edge_stage_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, number of datapath stages: 0 blur, 1 gradient, 2 nms, 3 threshold.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1048576, watchdog limit per wait phase.
REQ-003 SHALL have port clk  in  1  clock; all logic rising-edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports start in 1 (frame request), abort in 1 (cancel), regen_kernel in 1 (force kernel rebuild, sampled with start), bypass_mask in NUM_STAGES (skip stage i when bit i set, sampled with start).
REQ-006 SHALL have ports kgen_reset out 1 (clear kernel generator), kgen_enable out 1 (run generator), kgen_done in 1 (generator sticky done).
REQ-007 SHALL have ports stage_start out NUM_STAGES (one-hot start pulse), stage_done in NUM_STAGES (one-cycle done per stage).
REQ-008 SHALL have ports busy out 1, done out 1 (frame-complete pulse), error out 1 (sticky fault), cur_stage out 3 (active stage index, 7 when none), frame_count out 16 (completed frames).

Function
REQ-009 SHALL implement states IDLE, KRST, KGEN, ISSUE, WAIT, FDONE, ERR.
REQ-010 IDLE: start high -> latch bypass_mask; KRST if regen_kernel high or kernel_valid low, else ISSUE with stage index 0; start ignored in any other state.
REQ-011 KRST: kgen_reset high exactly one cycle, kernel_valid cleared -> KGEN.
REQ-012 KGEN: kgen_enable high every cycle; kgen_done high -> set kernel_valid, kgen_enable low next cycle, -> ISSUE with index 0.
REQ-013 ISSUE with latched bypass bit set: no pulse, index+1, one cycle per skipped stage; bit clear: stage_start[index] high one cycle -> WAIT.
REQ-014 WAIT: stage_done[index] high -> index+1 -> ISSUE, or -> FDONE when index was NUM_STAGES-1; ISSUE with index = NUM_STAGES also -> FDONE.
REQ-015 WAIT: any stage_done bit other than index high -> ERR, even if same-cycle done on index.
REQ-016 FDONE: done high one cycle, frame_count+1 (wraps 65535 -> 0) -> IDLE.
REQ-017 all-bypass frame with valid kernel: start cycle N, done high cycle N+NUM_STAGES+2.
REQ-018 abort high in any state except IDLE -> IDLE next cycle, no done, frame_count unchanged, kernel_valid kept only if already set, error cleared; abort beats every other transition in the same cycle.
REQ-019 ERR: error high, busy high, outputs otherwise idle; exits only on abort or reset.
REQ-020 busy SHALL be high in every state except IDLE; cur_stage = index in ISSUE/WAIT, else 7.
REQ-021 stage_start, kgen_reset, done SHALL never be high in two consecutive cycles from one transition.

Reset
REQ-022 reset SHALL force IDLE, kernel_valid 0, index 0, latched mask 0, frame_count 0, all outputs low except cur_stage = 7.
REQ-023 reset mid-frame SHALL discard the frame with no done pulse; next start rebuilds kernel.

Configuration
REQ-024 with SEQ_TIMEOUT_EN defined, watchdog SHALL count cycles spent in KGEN or WAIT, clear on phase entry, and force ERR when count reaches TIMEOUT_CYCLES.
REQ-025 without SEQ_TIMEOUT_EN, no watchdog logic SHALL exist; KGEN/WAIT wait indefinitely; TIMEOUT_CYCLES unused.

Structure
REQ-026 package edge_seq_pkg SHALL hold state enum, stage index constants (STG_BLUR, STG_GRAD, STG_NMS, STG_THRESH), CUR_STAGE_NONE = 7.
REQ-027 watchdog SHALL be sub-module seq_watchdog (clear, count_en, expired), instantiated only under SEQ_TIMEOUT_EN.

Verification
REQ-028 first start after reset, mask 0, kgen_done 6 cycles after enable, each stage done 3 cycles after start -> kgen_reset 1 pulse, 4 ordered stage_start pulses, done once, frame_count 1.
REQ-029 second start, regen_kernel 0, mask 4'b0101 -> no kgen_reset, stage_start only for stages 1 and 3, frame_count 2.
REQ-030 stage_done[2] asserted while waiting on stage 1 -> error high next cycle, held until abort, then IDLE with error 0.
REQ-031 abort same cycle as final stage_done -> IDLE, no done, frame_count unchanged.
REQ-032 SEQ_TIMEOUT_EN, TIMEOUT_CYCLES 16, stage_done withheld -> ERR after 16 WAIT cycles; without macro, still WAIT after 1000 cycles.
REQ-033 reset asserted during KGEN -> all outputs reset values same cycle; next start issues kgen_reset.

Source files
------------

// File: rtl/edge_seq_pkg.sv
// Shared types and constants for the edge-detection stage sequencer.
package edge_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KRST,
    S_KGEN,
    S_ISSUE,
    S_WAIT,
    S_FDONE,
    S_ERR
  } seq_state_e;

  localparam int STG_BLUR   = 0;
  localparam int STG_GRAD   = 1;
  localparam int STG_NMS    = 2;
  localparam int STG_THRESH = 3;

  localparam logic [2:0] CUR_STAGE_NONE = 3'd7;

endpackage

// File: rtl/seq_watchdog.sv
// Phase watchdog: counts enabled cycles since the last clear and flags the limit.
// Only instantiated when SEQ_TIMEOUT_EN is defined.
module seq_watchdog #(
  parameter int LIMIT = 1048576
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_count;

  // Expired is raised during the LIMIT-th counted cycle so the sequencer leaves on that edge.
  assign expired = count_en && (r_count == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_en && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/edge_stage_sequencer.sv
// Frame sequencer for the blur/gradient/nms/threshold edge pipeline with kernel rebuild.
// Optional watchdog on KGEN/WAIT phases when SEQ_TIMEOUT_EN is defined.
module edge_stage_sequencer
  import edge_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  regen_kernel,
  input  logic [NUM_STAGES-1:0] bypass_mask,
  output logic                  kgen_reset,
  output logic                  kgen_enable,
  input  logic                  kgen_done,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            cur_stage,
  output logic [15:0]           frame_count
);

  localparam int               IDX_W    = $clog2(NUM_STAGES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(NUM_STAGES);

  seq_state_e            r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [NUM_STAGES-1:0] r_mask, w_mask_nxt;
  logic                  r_kvalid, w_kvalid_nxt;
  logic [15:0]           r_fcount, w_fcount_nxt;

  logic [NUM_STAGES-1:0] w_idx_onehot;
  logic                  w_idx_bypass;
  logic                  w_hit;
  logic                  w_stray;
  logic                  w_timeout;

  // Index past the last stage decodes to an all-zero one-hot, so it never matches a bypass or done bit.
  always_comb begin
    w_idx_onehot = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_idx_onehot[i] = (r_idx == IDX_W'(i));
    end
  end

  assign w_idx_bypass = |(w_idx_onehot & r_mask);
  assign w_hit        = |(stage_done & w_idx_onehot);
  assign w_stray      = |(stage_done & ~w_idx_onehot);

`ifdef SEQ_TIMEOUT_EN
  logic w_wd_run;

  assign w_wd_run = (r_state == S_KGEN) || (r_state == S_WAIT);

  seq_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (!w_wd_run),
    .count_en(w_wd_run),
    .expired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_mask   <= '0;
      r_kvalid <= 1'b0;
      r_fcount <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_mask   <= w_mask_nxt;
      r_kvalid <= w_kvalid_nxt;
      r_fcount <= w_fcount_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_mask_nxt   = r_mask;
    w_kvalid_nxt = r_kvalid;
    w_fcount_nxt = r_fcount;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_mask_nxt = bypass_mask;
          w_idx_nxt  = '0;
          if (regen_kernel || !r_kvalid) begin
            w_state_nxt  = S_KRST;
            w_kvalid_nxt = 1'b0;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_KRST: w_state_nxt = S_KGEN;
      S_KGEN: begin
        if (w_timeout) begin
          w_state_nxt = S_ERR;
        end else if (kgen_done) begin
          w_kvalid_nxt = 1'b1;
          w_idx_nxt    = '0;
          w_state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_idx == END_IDX) begin
          w_state_nxt = S_FDONE;
        end else if (w_idx_bypass) begin
          w_idx_nxt = r_idx + 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      // A done from any other stage is a protocol fault even if our own done arrives with it.
      S_WAIT: begin
        if (w_stray || w_timeout) begin
          w_state_nxt = S_ERR;
        end else if (w_hit) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_FDONE;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_FDONE: begin
        w_fcount_nxt = r_fcount + 16'd1;
        w_state_nxt  = S_IDLE;
      end
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort overrides everything; an already-built kernel survives, nothing else is committed.
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt  = S_IDLE;
      w_idx_nxt    = '0;
      w_mask_nxt   = r_mask;
      w_kvalid_nxt = r_kvalid;
      w_fcount_nxt = r_fcount;
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_FDONE);
  assign error       = (r_state == S_ERR);
  assign kgen_reset  = (r_state == S_KRST);
  assign kgen_enable = (r_state == S_KGEN);
  assign stage_start = (r_state == S_ISSUE) ? (w_idx_onehot & ~r_mask) : '0;
  assign cur_stage   = ((r_state == S_ISSUE) || (r_state == S_WAIT)) ? 3'(r_idx) : CUR_STAGE_NONE;
  assign frame_count = r_fcount;

endmodule

// File: tb/tb_edge_stage_sequencer.sv
// Scoreboard bench for edge_stage_sequencer: a frame-level model queues expected
// events (kernel reset, stage starts, frame done) and a monitor consumes them.
module tb_edge_stage_sequencer;

  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, abort, regen_kernel;
  logic [NS-1:0] bypass_mask;
  logic          kgen_reset, kgen_enable, kgen_done;
  logic [NS-1:0] stage_start, stage_done;
  logic          busy, done, error;
  logic [2:0]    cur_stage;
  logic [15:0]   frame_count;

  int n_checks = 0;
  int n_fail   = 0;
  int sb[$];
  int m_fc = 0;
  bit m_kv = 1'b0;

  logic [NS-1:0] inj = '0;
  bit resp_en    = 1'b1;
  bit rand_delay = 1'b0;
  int sd_delay   = 3;
  int kg_delay   = 6;
  int sd_cnt     = -1;
  int sd_idx     = 0;
  int kg_cnt     = -1;

  always #5 clk = ~clk;

  edge_stage_sequencer #(
    .NUM_STAGES    (NS),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .regen_kernel(regen_kernel),
    .bypass_mask (bypass_mask),
    .kgen_reset  (kgen_reset),
    .kgen_enable (kgen_enable),
    .kgen_done   (kgen_done),
    .stage_start (stage_start),
    .stage_done  (stage_done),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .cur_stage   (cur_stage),
    .frame_count (frame_count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int start_tok(input logic [NS-1:0] s);
    int t = 99;
    for (int i = 0; i < NS; i++) if (s == (NS'(1) << i)) t = i;
    return t;
  endfunction

  task automatic sb_pop(input string name, input int act);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got unexpected event %0d, expected none", name, act);
    end else begin
      check(name, act, sb.pop_front());
    end
  endtask

  // Monitor: every observable event must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (kgen_reset === 1'b1) sb_pop("ev_kgen_reset", 100);
      if (stage_start !== '0)  sb_pop("ev_stage_start", start_tok(stage_start));
      if (done === 1'b1)       sb_pop("ev_done", 1000 + int'(frame_count));
    end
  end

  // Responder: kernel generator and stage engines with programmable latency.
  initial begin
    stage_done = '0;
    kgen_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sd_cnt     = -1;
        kg_cnt     = -1;
        kgen_done  = 1'b0;
        stage_done = '0;
      end else begin
        stage_done = inj;
        if (sd_cnt > 0) begin
          sd_cnt--;
          if (sd_cnt == 0 && resp_en) stage_done[sd_idx] = 1'b1;
        end
        if (stage_start != '0) begin
          sd_idx = start_tok(stage_start) % NS;
          sd_cnt = rand_delay ? int'($urandom_range(1, 5)) : sd_delay;
        end
        if (kgen_reset) begin
          kgen_done = 1'b0;
          kg_cnt    = -1;
        end else if (!kgen_enable) begin
          kg_cnt = -1;
        end else if (!kgen_done) begin
          if (kg_cnt < 0) kg_cnt = rand_delay ? int'($urandom_range(1, 8)) : kg_delay;
          else begin
            kg_cnt--;
            if (kg_cnt == 0) kgen_done = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [NS-1:0] mask, input bit regen);
    bypass_mask  = mask;
    regen_kernel = regen;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    regen_kernel = 1'b0;
    bypass_mask  = NS'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    do begin
      tick();
      k++;
    end while (busy !== 1'b0 && k < 2000);
    check(name, int'(busy), 0);
  endtask

  task automatic wait_for_start(input logic [NS-1:0] pat, input string name);
    int k = 0;
    while (stage_start !== pat && k < 200) begin
      tick();
      k++;
    end
    check(name, int'(stage_start), int'(pat));
  endtask

  task automatic run_frame(input logic [NS-1:0] mask, input bit regen);
    if (regen || !m_kv) sb.push_back(100);
    for (int i = 0; i < NS; i++) if (!mask[i]) sb.push_back(i);
    sb.push_back(1000 + m_fc);
    pulse_start(mask, regen);
    wait_idle("frame_idle");
    m_fc = (m_fc + 1) % 65536;
    m_kv = 1'b1;
    check("frame_count", int'(frame_count), m_fc);
    check("sb_drain", sb.size(), 0);
  endtask

  initial begin
    int first;
    int k;
    reset        = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    regen_kernel = 1'b0;
    bypass_mask  = '0;
    tick();
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_cur_stage", int'(cur_stage), 7);
    check("rst_frame_count", int'(frame_count), 0);
    check("rst_stage_start", int'(stage_start), 0);
    check("rst_kgen", int'({kgen_reset, kgen_enable}), 0);
    reset = 1'b0;
    tick();

    // First frame builds the kernel; second skips stages 0 and 2.
    run_frame(4'b0000, 1'b0);
    run_frame(4'b0101, 1'b0);

    // All-bypass latency: done expected NS+2 cycles after the start cycle.
    sb.push_back(1000 + m_fc);
    pulse_start('1, 1'b0);
    first = -1;
    for (k = 1; k <= 12; k++) begin
      if (done === 1'b1 && first < 0) first = k;
      tick();
    end
    check("bypass_done_cycle", first, NS + 2);
    m_fc++;
    check("bypass_frame_count", int'(frame_count), m_fc);
    check("bypass_sb_drain", sb.size(), 0);

    // Randomized frames.
    rand_delay = 1'b1;
    repeat (10) run_frame(NS'($urandom), ($urandom_range(0, 3) == 0));
    rand_delay = 1'b0;

    // Stray done from stage 2 while waiting on stage 1.
    resp_en = 1'b0;
    sb.push_back(0);
    sb.push_back(1);
    pulse_start('0, 1'b0);
    wait_for_start(4'b0001, "err_start0");
    inj = 4'b0001;
    tick();
    inj = '0;
    wait_for_start(4'b0010, "err_start1");
    tick();
    tick();
    inj = 4'b0100;
    tick();
    inj = '0;
    check("err_not_yet", int'(error), 0);
    tick();
    check("err_next_cycle", int'(error), 1);
    check("err_busy", int'(busy), 1);
    check("err_cur_stage", int'(cur_stage), 7);
    repeat (5) tick();
    check("err_held", int'(error), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("err_abort_error", int'(error), 0);
    check("err_abort_busy", int'(busy), 0);
    check("err_frame_count", int'(frame_count), m_fc);
    check("err_sb_drain", sb.size(), 0);
    repeat (6) tick();

    // Abort in the same cycle as the final stage done.
    sb.push_back(3);
    pulse_start(4'b0111, 1'b0);
    wait_for_start(4'b1000, "abort_start3");
    tick();
    inj = 4'b1000;
    tick();
    abort = 1'b1;
    inj   = '0;
    tick();
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    repeat (4) tick();
    check("abort_frame_count", int'(frame_count), m_fc);
    check("abort_sb_drain", sb.size(), 0);

    // Withheld stage done: watchdog behaviour.
    sb.push_back(0);
    pulse_start('0, 1'b0);
    wait_for_start(4'b0001, "wd_start0");
`ifdef SEQ_TIMEOUT_EN
    first = -1;
    for (k = 1; k <= 40; k++) begin
      tick();
      if (error === 1'b1 && first < 0) first = k;
    end
    check("wd_expire_cycle", first, 17);
`else
    repeat (1000) tick();
    check("wd_none_busy", int'(busy), 1);
    check("wd_none_error", int'(error), 0);
    check("wd_none_cur_stage", int'(cur_stage), 0);
`endif
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("wd_abort_busy", int'(busy), 0);
    check("wd_sb_drain", sb.size(), 0);
    repeat (6) tick();
    resp_en = 1'b1;

    // Reset during kernel generation, then the next frame must rebuild the kernel.
    kg_delay = 50;
    sb.push_back(100);
    pulse_start('0, 1'b1);
    k = 0;
    while (kgen_enable !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check("kgen_seen", int'(kgen_enable), 1);
    tick();
    reset = 1'b1;
    #1;
    check("mrst_busy", int'(busy), 0);
    check("mrst_kgen_enable", int'(kgen_enable), 0);
    check("mrst_cur_stage", int'(cur_stage), 7);
    check("mrst_frame_count", int'(frame_count), 0);
    m_fc = 0;
    m_kv = 1'b0;
    tick();
    reset    = 1'b0;
    kg_delay = 6;
    tick();
    check("mrst_sb_drain", sb.size(), 0);
    run_frame('0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
